fake_n64_controller_rx: RTL
===========================

Name: fake_n64_controller_rx

Overview:
Joybus receive front end for the fake N64 controller. Samples the console data line, decodes one command byte from the pulse-width-encoded bits, validates the console stop bit, then hands the line to the controller TX stage. It sits directly upstream of the TX stage: it drives that stage's cmd and cur_operation inputs and consumes its rx_handoff output.

Parameters:
LEVEL_WIDTH, 2, sample_clk cycles per Joybus level; bit = 4 levels.
IDLE_TIMEOUT, 16, max high cycles tolerated between bits inside a frame.

Ports:
sample_clk  input  1  sole clock; all logic on rising edge
reset  input  1  synchronous, active-high
data_rx  input  1  console data line (open-drain, externally pulled up; idle high)
rx_handoff  input  1  pulse from TX stage: response done, return line to RX
cmd  output  8  last received command byte, MSB first on wire
cmd_valid  output  1  one-cycle pulse when cmd updates
cur_operation  output  1  0 = Rx owns line, 1 = Tx owns line
frame_err  output  1  one-cycle pulse on malformed frame

Behaviour:
- Reset (sync, active-high): state IDLE; cmd=8'h00, cmd_valid=0, cur_operation=0, frame_err=0; sync flops and previous-sample reg =1; counters =0. Reset asserted in any state, including HANDOFF, forces this within one cycle.
- Input path: 2-flop synchronizer -> rx_s; rx_q = rx_s delayed 1 cycle; fall = rx_q & ~rx_s, rise = ~rx_q & rx_s. Decode latency 2 cycles from pin.
- Derived: THRESH = 2*LEVEL_WIDTH (4), MAX_LOW = 4*LEVEL_WIDTH (8), STOP_HIGH = 2*LEVEL_WIDTH (4).
- 6-bit cycle counter cnt, saturating at 63, cleared on every edge; 4-bit bit counter bit_cnt.
- States:
  IDLE: cur_operation=0. On fall -> LOW, cnt=1, bit_cnt=0.
  LOW: cnt increments while rx_s=0. cnt>MAX_LOW -> frame_err, IDLE. On rise: if bit_cnt<8, shift bit (cnt<THRESH ? 1 : 0) into shift reg LSB, bit_cnt++, -> HIGH. If bit_cnt==8 (stop position): cnt<THRESH -> STOP_WAIT; else frame_err, IDLE (covers 9th data bit, e.g. multi-byte 0x02/0x03 frames; these are unsupported).
  HIGH: cnt increments while rx_s=1. cnt>IDLE_TIMEOUT -> frame_err, IDLE. On fall -> LOW, cnt=1.
  STOP_WAIT: rx_s must stay 1 for STOP_HIGH cycles. Fall earlier -> frame_err, IDLE. On reaching STOP_HIGH: cmd<=shift reg, cmd_valid=1 for that cycle, cur_operation<=1, -> HANDOFF.
  HANDOFF: cur_operation=1; data_rx ignored (TX drives line). On rx_handoff=1 -> cur_operation<=0, IDLE next cycle. rx_handoff in any other state ignored.
- cmd holds its value until next valid frame; errored frames never update cmd.
- cmd_valid and frame_err never asserted together; each is exactly one cycle.
- Edge exactly at cnt==THRESH decodes as 0.

Test Plan:
- Reset, line high 20 cycles -> cmd=00, cmd_valid=0, cur_operation=0, frame_err=0.
- Send 0x01 (seven bits L6/H2, one bit L2/H6, stop L2 then high) -> cmd_valid pulse 4 cycles after stop rise seen on rx_s; cmd=8'h01; cur_operation=1 the same cycle as cmd_valid and held.
- From HANDOFF, toggle data_rx randomly 50 cycles then pulse rx_handoff -> cmd unchanged, no cmd_valid/frame_err during toggling; cur_operation=0 next cycle; subsequent 0xFF frame -> cmd=8'hFF.
- 0x00 frame followed by 9th L6 pulse at stop position -> frame_err pulse, cmd unchanged, cur_operation stays 0.
- Low held 9 cycles mid-byte -> frame_err on cycle cnt=9; high gap of 17 cycles after bit 3 -> frame_err; next clean 0x00 frame decodes cmd=8'h00.
- Assert reset during bit 5 of a frame and during HANDOFF -> all outputs at reset values next cycle; following 0x01 frame decodes correctly.

Source files
------------

// File: rtl/fake_n64_controller_rx.sv
// fake_n64_controller_rx
// Joybus receive front end: synchronizes the console data line, decodes one
// pulse-width-encoded command byte, validates the console stop bit, and then
// hands line ownership to the TX stage until it signals completion.
//
// Ports:
//   sample_clk     in   sole clock, rising edge
//   reset          in   synchronous, active-high
//   data_rx        in   console data line (idle high)
//   rx_handoff     in   TX stage done pulse; returns the line to RX
//   cmd[7:0]       out  last good command byte (MSB first on the wire)
//   cmd_valid      out  one-cycle pulse when cmd updates
//   cur_operation  out  0 = RX owns line, 1 = TX owns line
//   frame_err      out  one-cycle pulse on a malformed frame
module fake_n64_controller_rx #(
  parameter int unsigned LEVEL_WIDTH  = 2,
  parameter int unsigned IDLE_TIMEOUT = 16
) (
  input  logic       sample_clk,
  input  logic       reset,
  input  logic       data_rx,
  input  logic       rx_handoff,
  output logic [7:0] cmd,
  output logic       cmd_valid,
  output logic       cur_operation,
  output logic       frame_err
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned BIT_W = 4;
  localparam int unsigned CMD_W = 8;

  localparam logic [CNT_W-1:0] THRESH    = CNT_W'(2 * LEVEL_WIDTH);
  localparam logic [CNT_W-1:0] MAX_LOW   = CNT_W'(4 * LEVEL_WIDTH);
  localparam logic [CNT_W-1:0] STOP_HIGH = CNT_W'(2 * LEVEL_WIDTH);
  localparam logic [CNT_W-1:0] TIMEOUT   = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] DATA_BITS = BIT_W'(CMD_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_STOP_WAIT,
    S_HANDOFF
  } state_t;

  // Input synchronizer and edge-detect history
  logic             r_sync1;
  logic             r_rx_s;
  logic             r_rx_q;

  // Frame decode state
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [CMD_W-1:0] r_shift;

  // Registered outputs
  logic [CMD_W-1:0] r_cmd;
  logic             r_cmd_valid;
  logic             r_cur_op;
  logic             r_frame_err;

  // Combinational next values
  logic             w_fall;
  logic             w_rise;
  logic             w_bit;
  logic [CNT_W-1:0] w_cnt_inc;
  state_t           w_state_nx;
  logic [CNT_W-1:0] w_cnt_nx;
  logic [BIT_W-1:0] w_bit_cnt_nx;
  logic [CMD_W-1:0] w_shift_nx;
  logic [CMD_W-1:0] w_cmd_nx;
  logic             w_cmd_valid_nx;
  logic             w_cur_op_nx;
  logic             w_frame_err_nx;

  assign w_fall    = r_rx_q & ~r_rx_s;
  assign w_rise    = ~r_rx_q & r_rx_s;
  // A short low is a 1; a low lasting THRESH cycles or more is a 0
  assign w_bit     = (r_cnt < THRESH);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : (r_cnt + CNT_ONE);

  // Next-state and output decode
  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_bit_cnt_nx   = r_bit_cnt;
    w_shift_nx     = r_shift;
    w_cmd_nx       = r_cmd;
    w_cmd_valid_nx = 1'b0;
    w_cur_op_nx    = r_cur_op;
    w_frame_err_nx = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cur_op_nx = 1'b0;
        if (w_fall) begin
          w_state_nx   = S_LOW;
          w_cnt_nx     = CNT_ONE;
          w_bit_cnt_nx = '0;
        end
      end

      S_LOW: begin
        if (w_rise) begin
          w_cnt_nx = CNT_ONE;
          if (r_bit_cnt < DATA_BITS) begin
            w_shift_nx   = {r_shift[CMD_W-2:0], w_bit};
            w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
            w_state_nx   = S_HIGH;
          end else if (r_cnt < THRESH) begin
            w_state_nx = S_STOP_WAIT;
          end else begin
            // A long low in the stop slot is a 9th data bit: unsupported
            w_frame_err_nx = 1'b1;
            w_cnt_nx       = '0;
            w_state_nx     = S_IDLE;
          end
        end else if (w_cnt_inc > MAX_LOW) begin
          w_frame_err_nx = 1'b1;
          w_cnt_nx       = '0;
          w_state_nx     = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end

      S_HIGH: begin
        if (w_fall) begin
          w_cnt_nx   = CNT_ONE;
          w_state_nx = S_LOW;
        end else if (w_cnt_inc > TIMEOUT) begin
          w_frame_err_nx = 1'b1;
          w_cnt_nx       = '0;
          w_state_nx     = S_IDLE;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end

      S_STOP_WAIT: begin
        if (w_fall) begin
          w_frame_err_nx = 1'b1;
          w_cnt_nx       = '0;
          w_state_nx     = S_IDLE;
        end else if (w_cnt_inc >= STOP_HIGH) begin
          // Stop bit confirmed: publish the byte and give the line to TX
          w_cmd_nx       = r_shift;
          w_cmd_valid_nx = 1'b1;
          w_cur_op_nx    = 1'b1;
          w_cnt_nx       = '0;
          w_state_nx     = S_HANDOFF;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end

      S_HANDOFF: begin
        // TX drives the line here, so data_rx is not interpreted
        w_cur_op_nx = 1'b1;
        if (rx_handoff) begin
          w_cur_op_nx = 1'b0;
          w_state_nx  = S_IDLE;
        end
      end

      default: begin
        w_cur_op_nx = 1'b0;
        w_cnt_nx    = '0;
        w_state_nx  = S_IDLE;
      end
    endcase
  end

  // State, synchronizer and output registers
  always_ff @(posedge sample_clk) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_q      <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_cmd       <= '0;
      r_cmd_valid <= 1'b0;
      r_cur_op    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= data_rx;
      r_rx_s      <= r_sync1;
      r_rx_q      <= r_rx_s;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_bit_cnt   <= w_bit_cnt_nx;
      r_shift     <= w_shift_nx;
      r_cmd       <= w_cmd_nx;
      r_cmd_valid <= w_cmd_valid_nx;
      r_cur_op    <= w_cur_op_nx;
      r_frame_err <= w_frame_err_nx;
    end
  end

  assign cmd           = r_cmd;
  assign cmd_valid     = r_cmd_valid;
  assign cur_operation = r_cur_op;
  assign frame_err     = r_frame_err;

endmodule
